// File: rtl/uart_dl11_ctl_pkg.sv
// ============================================================================
// Module   : uart_dl11_ctl_pkg
// Purpose  : Register offsets, bit positions and FSM encodings for the DL11 console.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_dl11_ctl_pkg;

    localparam logic [1:0] ADDR_RCSR = 2'd0;
    localparam logic [1:0] ADDR_RBUF = 2'd1;
    localparam logic [1:0] ADDR_XCSR = 2'd2;
    localparam logic [1:0] ADDR_XBUF = 2'd3;

    localparam int BIT_DONE  = 7;
    localparam int BIT_IE    = 6;
    localparam int BIT_READY = 7;
    localparam int BIT_ERR   = 15;
    localparam int BIT_OVR   = 14;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_BUSY = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        R_WAIT = 2'd0,
        R_UNLD = 2'd1,
        R_CAPT = 2'd2
    } rx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// ============================================================================
// Module   : uart_baud_gen
// Purpose  : Divides clk into the UART rxclk (16x baud) and txclk (baud).
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_baud_gen #(
    parameter int RX_DIV = 326
) (
    input  logic clk,
    input  logic reset,
    output logic rxclk_o,
    output logic txclk_o
);

    localparam logic [15:0] DIV_LAST = 16'(RX_DIV - 1);
    localparam logic [15:0] DIV_HALF = 16'(RX_DIV / 2);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [2:0]  rise_cnt_q;
    logic        rxclk_q;
    logic        txclk_q;

    assign cnt_d = (cnt_q == DIV_LAST) ? 16'd0 : cnt_q + 16'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= 16'd0;
            rise_cnt_q <= 3'd0;
            rxclk_q    <= 1'b0;
            txclk_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rxclk_q <= (cnt_q < DIV_HALF);
            // Count 0 is the edge on which rxclk rises.
            if (cnt_q == 16'd0) begin
                rise_cnt_q <= rise_cnt_q + 3'd1;
                if (rise_cnt_q == 3'd7) begin
                    txclk_q <= ~txclk_q;
                end
            end
        end
    end

    assign rxclk_o = rxclk_q;
    assign txclk_o = txclk_q;

endmodule

`default_nettype wire

// File: rtl/uart_dl11_ctl.sv
// ============================================================================
// Module   : uart_dl11_ctl
// Purpose  : DL11 console register file and handshake sequencer for a byte UART.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_dl11_ctl
    import uart_dl11_ctl_pkg::*;
#(
    parameter int RX_DIV = 326
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  bus_addr,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [15:0] bus_wdata,
    output logic [15:0] bus_rdata,
    output logic        rx_irq,
    output logic        tx_irq,
    output logic        uart_rxclk,
    output logic        uart_txclk,
    output logic        uart_ld_tx_data,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_enable,
    input  logic        uart_tx_empty,
    output logic        uart_uld_rx_data,
    input  logic [7:0]  uart_rx_data,
    output logic        uart_rx_enable,
    input  logic        uart_rx_empty
);

    tx_state_e   tx_state_q;
    rx_state_e   rx_state_q;
    logic        enable_q;
    logic [1:0]  tx_empty_sync_q;
    logic [1:0]  rx_empty_sync_q;
    logic        tx_empty_s;
    logic        rx_empty_s;
    logic        ld_q;
    logic [7:0]  tx_data_q;
    logic        ready_q;
    logic        xie_q;
    logic        uld_q;
    logic        done_q;
    logic        ovr_q;
    logic        rie_q;
    logic [7:0]  rbuf_data_q;
    logic        wr_rcsr;
    logic        wr_xcsr;
    logic        wr_xbuf;
    logic        rd_rbuf;
    logic        unused_wdata;

    uart_baud_gen #(
        .RX_DIV (RX_DIV)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .rxclk_o (uart_rxclk),
        .txclk_o (uart_txclk)
    );

    assign wr_rcsr      = bus_wr && (bus_addr == ADDR_RCSR);
    assign wr_xcsr      = bus_wr && (bus_addr == ADDR_XCSR);
    assign wr_xbuf      = bus_wr && (bus_addr == ADDR_XBUF);
    assign rd_rbuf      = bus_rd && (bus_addr == ADDR_RBUF);
    assign unused_wdata = ^bus_wdata[15:8];

    // Empty flags come from the UART's own clock domains; reset high = "empty".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q        <= 1'b0;
            tx_empty_sync_q <= 2'b11;
            rx_empty_sync_q <= 2'b11;
        end else begin
            enable_q        <= 1'b1;
            tx_empty_sync_q <= {tx_empty_sync_q[0], uart_tx_empty};
            rx_empty_sync_q <= {rx_empty_sync_q[0], uart_rx_empty};
        end
    end

    assign tx_empty_s = tx_empty_sync_q[1];
    assign rx_empty_s = rx_empty_sync_q[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= T_IDLE;
            ld_q       <= 1'b0;
            tx_data_q  <= 8'd0;
            ready_q    <= 1'b1;
            xie_q      <= 1'b0;
        end else begin
            if (wr_xcsr) begin
                xie_q <= bus_wdata[BIT_IE];
            end
            case (tx_state_q)
                T_IDLE: begin
                    if (wr_xbuf && ready_q) begin
                        tx_data_q  <= bus_wdata[7:0];
                        ready_q    <= 1'b0;
                        ld_q       <= 1'b1;
                        tx_state_q <= T_LOAD;
                    end
                end
                T_LOAD: begin
                    if (!tx_empty_s) begin
                        ld_q       <= 1'b0;
                        tx_state_q <= T_BUSY;
                    end
                end
                T_BUSY: begin
                    if (tx_empty_s) begin
                        ready_q    <= 1'b1;
                        tx_state_q <= T_IDLE;
                    end
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q  <= R_WAIT;
            uld_q       <= 1'b0;
            done_q      <= 1'b0;
            ovr_q       <= 1'b0;
            rie_q       <= 1'b0;
            rbuf_data_q <= 8'd0;
        end else begin
            if (wr_rcsr) begin
                rie_q <= bus_wdata[BIT_IE];
            end
            if (rd_rbuf) begin
                done_q <= 1'b0;
                ovr_q  <= 1'b0;
            end
            case (rx_state_q)
                R_WAIT: begin
                    if (!rx_empty_s) begin
                        uld_q      <= 1'b1;
                        rx_state_q <= R_UNLD;
                    end
                end
                R_UNLD: begin
                    if (rx_empty_s) begin
                        uld_q      <= 1'b0;
                        rx_state_q <= R_CAPT;
                    end
                end
                R_CAPT: begin
                    // Overrides a coincident RBUF read; that read consumed the prior byte.
                    rbuf_data_q <= uart_rx_data;
                    ovr_q       <= done_q & ~rd_rbuf;
                    done_q      <= 1'b1;
                    rx_state_q  <= R_WAIT;
                end
                default: rx_state_q <= R_WAIT;
            endcase
        end
    end

    always_comb begin
        bus_rdata = 16'd0;
        case (bus_addr)
            ADDR_RCSR: begin
                bus_rdata[BIT_DONE] = done_q;
                bus_rdata[BIT_IE]   = rie_q;
            end
            ADDR_RBUF: begin
                bus_rdata[BIT_ERR]  = ovr_q;
                bus_rdata[BIT_OVR]  = ovr_q;
                bus_rdata[7:0]      = rbuf_data_q;
            end
            ADDR_XCSR: begin
                bus_rdata[BIT_READY] = ready_q;
                bus_rdata[BIT_IE]    = xie_q;
            end
            default: bus_rdata = 16'd0;
        endcase
    end

    assign rx_irq           = done_q & rie_q;
    assign tx_irq           = ready_q & xie_q;
    assign uart_ld_tx_data  = ld_q;
    assign uart_tx_data     = tx_data_q;
    assign uart_uld_rx_data = uld_q;
    assign uart_tx_enable   = enable_q;
    assign uart_rx_enable   = enable_q;

endmodule

`default_nettype wire
